// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC result drain path.
// Holds the pair layout, the byte-select encoding and the default pair depth.
package cordic_pkg;

  localparam int DEPTH_DEF = 4;

  typedef enum logic {
    SEL_X = 1'b0,
    SEL_Y = 1'b1
  } sel_e;

  typedef struct packed {
    logic [7:0] nx;
    logic [7:0] ny;
  } pair_t;

endpackage

// File: rtl/cordic_pair_fifo.sv
// Pair FIFO: DEPTH entries of {nx, ny}; pointers carry an extra wrap bit.
// Data and flags are visible the cycle after a push; the caller gates push/pop.
module cordic_pair_fifo
  import cordic_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   ck,
  input  logic                   raz,
  input  logic                   i_push,
  input  pair_t                  i_wdat,
  input  logic                   i_pop,
  output pair_t                  o_rdat,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wp;
  logic [AW:0] r_rp;
  pair_t       r_mem [DEPTH];

  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
  assign o_level = r_wp - r_rp;
  assign o_rdat  = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge ck or negedge raz) begin
    if (!raz) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (i_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  // Storage is deliberately left out of reset; the pointers alone define validity.
  always_ff @(posedge ck) begin
    if (i_push) r_mem[r_wp[AW-1:0]] <= i_wdat;
  end

endmodule

// File: rtl/cordic_out.sv
// Drains rotator (nx, ny) pairs into a FIFO and serialises them nx-then-ny on a byte channel.
// Outputs decode registered state only; a pair frees its slot when its ny byte is taken.
module cordic_out
  import cordic_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   ck,
  input  logic                   raz,
  input  logic                   rok_nxy_p,
  input  logic [7:0]             nx_p,
  input  logic [7:0]             ny_p,
  output logic                   rd_nxy_p,
  input  logic                   rd_b_p,
  output logic                   rok_b_p,
  output logic [7:0]             b_p,
  output logic                   sel_p,
  output logic [$clog2(DEPTH):0] level_p
);

  sel_e  r_sel;
  logic  w_full;
  logic  w_empty;
  logic  w_push;
  logic  w_byte_pop;
  logic  w_pair_pop;
  pair_t w_wdat;
  pair_t w_head;

  assign w_wdat     = '{nx: nx_p, ny: ny_p};
  assign w_push     = rok_nxy_p & rd_nxy_p;
  assign w_byte_pop = rok_b_p & rd_b_p;
  assign w_pair_pop = w_byte_pop & (r_sel == SEL_Y);

  cordic_pair_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .ck      (ck),
    .raz     (raz),
    .i_push  (w_push),
    .i_wdat  (w_wdat),
    .i_pop   (w_pair_pop),
    .o_rdat  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level_p)
  );

  // Full is registered state, so a same-cycle ny pop never opens a slot for a push.
  assign rd_nxy_p = ~w_full & raz;
  assign rok_b_p  = ~w_empty;
  assign sel_p    = r_sel;
  assign b_p      = (r_sel == SEL_Y) ? w_head.ny : w_head.nx;

  always_ff @(posedge ck or negedge raz) begin
    if (!raz) begin
      r_sel <= SEL_X;
    end else if (w_byte_pop) begin
      r_sel <= (r_sel == SEL_X) ? SEL_Y : SEL_X;
    end
  end

endmodule
